// File: rtl/decode_stage.sv
// RV32I decode stage: register file, immediate/control decode and the ID/EX pipeline register.
// Optional build macro DECODE_BYPASS_EN forwards same-cycle writeback data into the operands.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instrD,
    input  logic [XLEN-1:0] PCD,
    input  logic            flushE,
    input  logic            regWriteW,
    input  logic [4:0]      rdW,
    input  logic [XLEN-1:0] resultW,
    output logic [XLEN-1:0] rd1E,
    output logic [XLEN-1:0] rd2E,
    output logic [XLEN-1:0] immE,
    output logic [XLEN-1:0] PCE,
    output logic [4:0]      rs1E,
    output logic [4:0]      rs2E,
    output logic [4:0]      rdE,
    output logic [2:0]      funct3E,
    output logic [3:0]      ALUcontrolE,
    output logic            ALUsrcE,
    output logic            srcAPCE,
    output logic [1:0]      resultSrcE,
    output logic            regWriteE,
    output logic            memWriteE,
    output logic            branchE,
    output logic            jumpE,
    output logic            illegalE
);

    localparam int unsigned REGW = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } aluOpT;

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [2:0]      funct3;
        aluOpT           aluCtrl;
        logic            aluSrc;
        logic            srcAPC;
        logic [1:0]      resultSrc;
        logic            regWrite;
        logic            memWrite;
        logic            branch;
        logic            jump;
        logic            illegal;
    } idExT;

    // Shared R/I-ALU funct3 map; alt selects SUB (R only) and SRA.
    function automatic aluOpT aluFromFunct(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  aluFromFunct = alt ? ALU_SUB : ALU_ADD;
            3'b001:  aluFromFunct = ALU_SLL;
            3'b010:  aluFromFunct = ALU_SLT;
            3'b011:  aluFromFunct = ALU_SLTU;
            3'b100:  aluFromFunct = ALU_XOR;
            3'b101:  aluFromFunct = alt ? ALU_SRA : ALU_SRL;
            3'b110:  aluFromFunct = ALU_OR;
            default: aluFromFunct = ALU_AND;
        endcase
    endfunction

    logic [XLEN-1:0] regs [0:NREGS-1];
    idExT            idEx;
    idExT            dec;
    idExT            nxt;
    logic [6:0]      opcode;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [XLEN-1:0] rf1;
    logic [XLEN-1:0] rf2;

    assign opcode = instrD[6:0];
    assign rs1    = instrD[19:15];
    assign rs2    = instrD[24:20];

    // Register file; x0 is never written and always reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (regWriteW && (rdW != '0)) begin
            regs[rdW] <= resultW;
        end
    end

    always_comb begin
        rf1 = (rs1 == '0) ? '0 : regs[rs1];
        rf2 = (rs2 == '0) ? '0 : regs[rs2];
`ifdef DECODE_BYPASS_EN
        if (regWriteW && (rdW != '0) && (rdW == rs1)) rf1 = resultW;
        if (regWriteW && (rdW != '0) && (rdW == rs2)) rf2 = resultW;
`endif
    end

    // Control and immediate decode.
    always_comb begin
        dec        = '0;
        dec.rd1    = rf1;
        dec.rd2    = rf2;
        dec.pc     = PCD;
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.rd     = instrD[11:7];
        dec.funct3 = instrD[14:12];
        case (opcode)
            OP_R: begin
                dec.aluCtrl  = aluFromFunct(instrD[14:12], instrD[30]);
                dec.regWrite = 1'b1;
            end
            OP_IALU: begin
                dec.imm      = {{20{instrD[31]}}, instrD[31:20]};
                dec.aluCtrl  = aluFromFunct(instrD[14:12],
                                            instrD[30] && (instrD[14:12] == 3'b101));
                dec.aluSrc   = 1'b1;
                dec.regWrite = 1'b1;
            end
            OP_LOAD: begin
                dec.imm       = {{20{instrD[31]}}, instrD[31:20]};
                dec.aluSrc    = 1'b1;
                dec.resultSrc = 2'b01;
                dec.regWrite  = 1'b1;
            end
            OP_STORE: begin
                dec.imm      = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
                dec.aluSrc   = 1'b1;
                dec.memWrite = 1'b1;
            end
            OP_BRANCH: begin
                dec.imm     = {{19{instrD[31]}}, instrD[31], instrD[7],
                               instrD[30:25], instrD[11:8], 1'b0};
                dec.aluCtrl = ALU_SUB;
                dec.branch  = 1'b1;
            end
            OP_JAL: begin
                dec.imm       = {{11{instrD[31]}}, instrD[31], instrD[19:12],
                                 instrD[20], instrD[30:21], 1'b0};
                dec.aluSrc    = 1'b1;
                dec.srcAPC    = 1'b1;
                dec.resultSrc = 2'b10;
                dec.regWrite  = 1'b1;
                dec.jump      = 1'b1;
            end
            OP_JALR: begin
                dec.imm       = {{20{instrD[31]}}, instrD[31:20]};
                dec.aluSrc    = 1'b1;
                dec.resultSrc = 2'b10;
                dec.regWrite  = 1'b1;
                dec.jump      = 1'b1;
            end
            OP_LUI: begin
                dec.imm      = {instrD[31:12], 12'b0};
                dec.rs1      = '0;
                dec.rd1      = '0;
                dec.aluSrc   = 1'b1;
                dec.regWrite = 1'b1;
            end
            OP_AUIPC: begin
                dec.imm      = {instrD[31:12], 12'b0};
                dec.aluSrc   = 1'b1;
                dec.srcAPC   = 1'b1;
                dec.regWrite = 1'b1;
            end
            default: begin
                // All-zero word is a fetch bubble, not an illegal instruction.
                dec.illegal = (instrD != '0);
            end
        endcase
        nxt = flushE ? '0 : dec;
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idEx <= '0;
        end else begin
            idEx <= nxt;
        end
    end

    assign rd1E        = idEx.rd1;
    assign rd2E        = idEx.rd2;
    assign immE        = idEx.imm;
    assign PCE         = idEx.pc;
    assign rs1E        = idEx.rs1;
    assign rs2E        = idEx.rs2;
    assign rdE         = idEx.rd;
    assign funct3E     = idEx.funct3;
    assign ALUcontrolE = idEx.aluCtrl;
    assign ALUsrcE     = idEx.aluSrc;
    assign srcAPCE     = idEx.srcAPC;
    assign resultSrcE  = idEx.resultSrc;
    assign regWriteE   = idEx.regWrite;
    assign memWriteE   = idEx.memWrite;
    assign branchE     = idEx.branch;
    assign jumpE       = idEx.jump;
    assign illegalE    = idEx.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expected values hand-derived from RV32I encodings.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrD;
    logic [31:0] PCD;
    logic        flushE;
    logic        regWriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;
    logic [31:0] rd1E, rd2E, immE, PCE;
    logic [4:0]  rs1E, rs2E, rdE;
    logic [2:0]  funct3E;
    logic [3:0]  ALUcontrolE;
    logic        ALUsrcE, srcAPCE;
    logic [1:0]  resultSrcE;
    logic        regWriteE, memWriteE, branchE, jumpE, illegalE;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] ADDI_X1  = 32'hFFB00093; // addi x1,x0,-5
    localparam logic [31:0] SUB_X3   = 32'h402081B3; // sub  x3,x1,x2
    localparam logic [31:0] BEQ_M8   = 32'hFE208CE3; // beq  x1,x2,-8
    localparam logic [31:0] ADD_X7   = 32'h00038433; // add  x8,x7,x0
    localparam logic [31:0] ADD_X6   = 32'h00030433; // add  x8,x6,x0
    localparam logic [31:0] ADD_X5   = 32'h00028433; // add  x8,x5,x0
    localparam logic [31:0] ADD_X0   = 32'h00000433; // add  x8,x0,x0
    localparam logic [31:0] LUI_X4   = 32'h12345237; // lui  x4,0x12345

    decode_stage dut (
        .clk(clk), .rst(rst), .instrD(instrD), .PCD(PCD), .flushE(flushE),
        .regWriteW(regWriteW), .rdW(rdW), .resultW(resultW),
        .rd1E(rd1E), .rd2E(rd2E), .immE(immE), .PCE(PCE),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .funct3E(funct3E),
        .ALUcontrolE(ALUcontrolE), .ALUsrcE(ALUsrcE), .srcAPCE(srcAPCE),
        .resultSrcE(resultSrcE), .regWriteE(regWriteE), .memWriteE(memWriteE),
        .branchE(branchE), .jumpE(jumpE), .illegalE(illegalE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        regWriteW = 1'b1; rdW = r; resultW = v; instrD = '0;
        step();
        regWriteW = 1'b0;
    endtask

    // All-zero check across the whole ID/EX output set.
    task automatic chkAllZero(input string tag);
        chk({tag, "_ctrl"}, {22'd0, ALUcontrolE, ALUsrcE, srcAPCE, resultSrcE,
                             regWriteE, memWriteE, branchE, jumpE, illegalE}, 32'd0);
        chk({tag, "_idx"}, {17'd0, rs1E, rs2E, rdE}, 32'd0);
        chk({tag, "_f3"}, {29'd0, funct3E}, 32'd0);
        chk({tag, "_imm"}, immE, 32'd0);
        chk({tag, "_rd1"}, rd1E, 32'd0);
        chk({tag, "_rd2"}, rd2E, 32'd0);
        chk({tag, "_pc"}, PCE, 32'd0);
    endtask

    initial begin
        rst = 1'b1; instrD = '0; PCD = '0; flushE = 1'b0;
        regWriteW = 1'b0; rdW = '0; resultW = '0;
        #3;
        chkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        wr(5'd1, 32'd10);
        wr(5'd2, 32'd3);
        wr(5'd5, 32'h77);
        wr(5'd7, 32'h55);

        instrD = ADDI_X1; PCD = 32'h100;
        step();
        chk("addi_imm", immE, 32'hFFFFFFFB);
        chk("addi_alu", {28'd0, ALUcontrolE}, 32'h0);
        chk("addi_src", {31'd0, ALUsrcE}, 32'd1);
        chk("addi_rw", {31'd0, regWriteE}, 32'd1);
        chk("addi_rd", {27'd0, rdE}, 32'd1);
        chk("addi_pc", PCE, 32'h100);

        instrD = SUB_X3; PCD = 32'h104;
        step();
        chk("sub_rd1", rd1E, 32'd10);
        chk("sub_rd2", rd2E, 32'd3);
        chk("sub_alu", {28'd0, ALUcontrolE}, 32'h1);
        chk("sub_src", {31'd0, ALUsrcE}, 32'd0);
        chk("sub_rd", {27'd0, rdE}, 32'd3);

        // Flushed branch; writeback of x6 must still commit.
        instrD = BEQ_M8; PCD = 32'h108; flushE = 1'b1;
        regWriteW = 1'b1; rdW = 5'd6; resultW = 32'h66;
        step();
        flushE = 1'b0; regWriteW = 1'b0;
        chkAllZero("flush");

        step();
        chk("beq_imm", immE, 32'hFFFFFFF8);
        chk("beq_br", {31'd0, branchE}, 32'd1);
        chk("beq_rw", {31'd0, regWriteE}, 32'd0);
        chk("beq_alu", {28'd0, ALUcontrolE}, 32'h1);
        chk("beq_rd2", rd2E, 32'd3);

        instrD = ADD_X6;
        step();
        chk("flush_wb_x6", rd1E, 32'h66);

        instrD = LUI_X4;
        step();
        chk("lui_imm", immE, 32'h12345000);
        chk("lui_rs1", {27'd0, rs1E}, 32'd0);
        chk("lui_rd", {27'd0, rdE}, 32'd4);

        // Same-cycle writeback while decoding a reader of x7.
        instrD = ADD_X7; regWriteW = 1'b1; rdW = 5'd7; resultW = 32'h1234;
        step();
        regWriteW = 1'b0;
`ifdef DECODE_BYPASS_EN
        chk("bypass_rd1", rd1E, 32'h1234);
`else
        chk("bypass_rd1", rd1E, 32'h55);
`endif
        chk("bypass_rs1", {27'd0, rs1E}, 32'd7);
        step();
        chk("x7_after", rd1E, 32'h1234);

        wr(5'd0, 32'hDEAD);
        chk("bubble_rw", {31'd0, regWriteE}, 32'd0);
        chk("bubble_ill", {31'd0, illegalE}, 32'd0);
        instrD = ADD_X0;
        step();
        chk("x0_rd1", rd1E, 32'd0);
        chk("x0_rd2", rd2E, 32'd0);

        instrD = 32'h0000007F;
        step();
        chk("ill_flag", {31'd0, illegalE}, 32'd1);
        chk("ill_rw", {31'd0, regWriteE}, 32'd0);

        // Mid-run asynchronous reset.
        instrD = ADDI_X1; PCD = 32'h200;
        step();
        chk("pre_rst_rw", {31'd0, regWriteE}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chkAllZero("async_rst");
        rst = 1'b0; instrD = ADD_X5; PCD = '0;
        step();
        chk("x5_cleared", rd1E, 32'd0);
        chk("x5_rs1", {27'd0, rs1E}, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
